// File: rtl/io_port_bridge_if.sv
// io_port_bridge_if
//  Bundles the CPU port pair and the two host streams of io_port_bridge.
//  slave  : the bridge side (drives cpu_in, host_in_ready, host_out_*, level, overflow)
//  master : the CPU/host side (drives cpu_out, host_in_data/valid, host_out_ready)
//  DEPTH must match the bridge's DEPTH; it sizes the level field.
interface io_port_bridge_if #(
    parameter int DEPTH = 8
);
    logic [15:0]              cpu_out;
    logic [15:0]              cpu_in;
    logic [15:0]              host_in_data;
    logic                     host_in_valid;
    logic                     host_in_ready;
    logic [15:0]              host_out_data;
    logic                     host_out_valid;
    logic                     host_out_ready;
    logic [$clog2(DEPTH):0]   level;
    logic                     overflow;

    modport slave (
        input  cpu_out, host_in_data, host_in_valid, host_out_ready,
        output cpu_in, host_in_ready, host_out_data, host_out_valid, level, overflow
    );

    modport master (
        output cpu_out, host_in_data, host_in_valid, host_out_ready,
        input  cpu_in, host_in_ready, host_out_data, host_out_valid, level, overflow
    );
endinterface

// File: rtl/io_port_bridge.sv
// io_port_bridge
//  Host-side counterpart of the CPU's 16-bit in/out ports.
//  Input path : host valid/ready words are loaded into cpu_in and held for HOLD
//               cycles before the next word is accepted.
//  Output path: every change on cpu_out is queued in a DEPTH-entry FIFO and
//               presented to the host as a show-ahead valid/ready stream.
// Ports
//  clk   : single clock, rising edge
//  reset : synchronous, active-low
//  bus   : io_port_bridge_if.slave (cpu_out/cpu_in, host_in_*, host_out_*,
//          level = FIFO occupancy 0..DEPTH, overflow = sticky drop flag)
module io_port_bridge #(
    parameter int          DEPTH      = 8,
    parameter int          HOLD       = 4,
    parameter logic [15:0] IN_DEFAULT = 16'h0000
) (
    input logic               clk,
    input logic               reset,
    io_port_bridge_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int HW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;

    logic [15:0]   cpu_in_q;
    logic [HW-1:0] hold_cnt;
    logic [15:0]   last_seen;
    logic          armed;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   level_q;
    logic          overflow_q;
    logic [15:0]   mem [DEPTH];

    logic accept;
    logic push;
    logic pop;
    logic full;
    logic nonempty;
    logic wr_en;

    assign nonempty = (level_q != '0);
    assign full     = (level_q == (AW + 1)'(DEPTH));
    assign accept   = bus.host_in_valid && (hold_cnt == '0);
    // cpu_out has no strobe; any difference from the previous edge is a word.
    assign push     = armed && (bus.cpu_out != last_seen);
    assign pop      = nonempty && bus.host_out_ready;
    // When full, a simultaneous pop frees the slot being written (wr_ptr==rd_ptr).
    assign wr_en    = push && (!full || pop);

    assign bus.cpu_in         = cpu_in_q;
    assign bus.host_in_ready  = (hold_cnt == '0);
    assign bus.host_out_valid = nonempty;
    assign bus.host_out_data  = nonempty ? mem[rd_ptr] : 16'h0000;
    assign bus.level          = level_q;
    assign bus.overflow       = overflow_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cpu_in_q   <= IN_DEFAULT;
            hold_cnt   <= '0;
            last_seen  <= '0;
            armed      <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            // Input path
            if (accept) begin
                cpu_in_q <= bus.host_in_data;
                hold_cnt <= HW'(HOLD);
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end

            // Change detector: the first edge only captures the baseline.
            last_seen <= bus.cpu_out;
            armed     <= 1'b1;

            // FIFO pointers and occupancy
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            if (push && full && !pop) overflow_q <= 1'b1;
        end
    end

    // Storage is not reset; level/pointers define what is valid.
    always_ff @(posedge clk) begin
        if (reset && wr_en) mem[wr_ptr] <= bus.cpu_out;
    end
endmodule

// File: tb/tb_io_port_bridge.sv
module tb_io_port_bridge;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    io_port_bridge_if #(.DEPTH(8)) bus ();
    io_port_bridge_if #(.DEPTH(8)) bus0 ();

    io_port_bridge #(.DEPTH(8), .HOLD(3), .IN_DEFAULT(16'h0000)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    io_port_bridge #(.DEPTH(8), .HOLD(0), .IN_DEFAULT(16'h0000)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.cpu_out = 16'h1234;
        tick();
        tick();
        checks++; if (bus.cpu_in !== 16'h0000) begin errors++; $display("FAIL reset_cpu_in got=%h exp=0000", bus.cpu_in); end
        checks++; if (bus.host_in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.host_in_ready); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.level !== 4'd0 || bus.host_out_valid !== 1'b0 || bus.cpu_in !== 16'h0000) begin
                errors++;
                $display("FAIL reset_idle[%0d] level=%0d valid=%b cpu_in=%h exp 0/0/0000", i, bus.level, bus.host_out_valid, bus.cpu_in);
            end
        end
    endtask

    task automatic test_change_detect();
        bus.host_out_ready = 1'b0;
        bus.cpu_out = 16'h0005; tick();
        bus.cpu_out = 16'h0005; tick();
        bus.cpu_out = 16'h0006; tick();
        tick();
        checks++; if (bus.level !== 4'd2) begin errors++; $display("FAIL chg_level got=%0d exp=2", bus.level); end
        checks++; if (bus.host_out_data !== 16'h0005) begin errors++; $display("FAIL chg_head0 got=%h exp=0005", bus.host_out_data); end
        bus.host_out_ready = 1'b1;
        tick();
        checks++; if (bus.host_out_data !== 16'h0006) begin errors++; $display("FAIL chg_head1 got=%h exp=0006", bus.host_out_data); end
        tick();
        checks++; if (bus.host_out_valid !== 1'b0 || bus.host_out_data !== 16'h0000) begin errors++; $display("FAIL chg_empty valid=%b data=%h exp 0/0000", bus.host_out_valid, bus.host_out_data); end
        bus.host_out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) begin
            bus.cpu_out = 16'(i);
            tick();
        end
        checks++; if (bus.level !== 4'd8) begin errors++; $display("FAIL ovf_level got=%0d exp=8", bus.level); end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", bus.overflow); end
        bus.host_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (bus.host_out_data !== 16'(i)) begin errors++; $display("FAIL ovf_pop[%0d] got=%h exp=%h", i, bus.host_out_data, 16'(i)); end
            tick();
        end
        checks++; if (bus.host_out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained valid=%b exp=0", bus.host_out_valid); end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); end
        bus.host_out_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        reset = 1'b0;
        tick();
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf_cleared got=%b exp=0", bus.overflow); end
        reset = 1'b1;
        tick(); // arms with cpu_out=0009
        for (int i = 0; i < 8; i++) begin
            bus.cpu_out = 16'h0010 + 16'(i);
            tick();
        end
        checks++; if (bus.level !== 4'd8) begin errors++; $display("FAIL fpp_full got=%0d exp=8", bus.level); end
        bus.cpu_out = 16'h0020;
        bus.host_out_ready = 1'b1;
        tick();
        checks++; if (bus.level !== 4'd8) begin errors++; $display("FAIL fpp_level got=%0d exp=8", bus.level); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf got=%b exp=0", bus.overflow); end
        checks++; if (bus.host_out_data !== 16'h0011) begin errors++; $display("FAIL fpp_head got=%h exp=0011", bus.host_out_data); end
        for (int i = 1; i < 8; i++) begin
            checks++;
            if (bus.host_out_data !== 16'h0010 + 16'(i)) begin errors++; $display("FAIL fpp_drain[%0d] got=%h exp=%h", i, bus.host_out_data, 16'h0010 + 16'(i)); end
            tick();
        end
        checks++; if (bus.host_out_data !== 16'h0020 || bus.level !== 4'd1) begin errors++; $display("FAIL fpp_tail data=%h level=%0d exp 0020/1", bus.host_out_data, bus.level); end
        tick();
        bus.host_out_ready = 1'b0;
    endtask

    task automatic test_hold();
        bus.host_in_valid = 1'b1;
        bus.host_in_data  = 16'hA5A5;
        tick();
        bus.host_in_data  = 16'h5A5A;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.cpu_in !== 16'hA5A5 || bus.host_in_ready !== 1'b0) begin errors++; $display("FAIL hold[%0d] cpu_in=%h ready=%b exp A5A5/0", i, bus.cpu_in, bus.host_in_ready); end
            tick();
        end
        checks++; if (bus.cpu_in !== 16'hA5A5 || bus.host_in_ready !== 1'b1) begin errors++; $display("FAIL hold_last cpu_in=%h ready=%b exp A5A5/1", bus.cpu_in, bus.host_in_ready); end
        tick();
        checks++; if (bus.cpu_in !== 16'h5A5A || bus.host_in_ready !== 1'b0) begin errors++; $display("FAIL hold_next cpu_in=%h ready=%b exp 5A5A/0", bus.cpu_in, bus.host_in_ready); end
        bus.host_in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [3];
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
        bus0.host_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus0.host_in_data = words[i];
            tick();
            checks++;
            if (bus0.cpu_in !== words[i] || bus0.host_in_ready !== 1'b1) begin errors++; $display("FAIL b2b[%0d] cpu_in=%h ready=%b exp %h/1", i, bus0.cpu_in, bus0.host_in_ready, words[i]); end
        end
        bus0.host_in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.host_out_ready = 1'b0;
        bus.host_in_valid = 1'b1;
        bus.host_in_data  = 16'hBEEF;
        for (int i = 0; i < 5; i++) begin
            bus.cpu_out = 16'h0030 + 16'(i);
            tick();
            bus.host_in_valid = 1'b0;
        end
        bus.host_in_valid = 1'b1;
        bus.host_in_data  = 16'hCAFE;
        tick();
        bus.host_in_valid = 1'b0;
        tick(); // hold_cnt now 2
        checks++; if (bus.level !== 4'd5 || bus.host_in_ready !== 1'b0 || bus.cpu_in !== 16'hCAFE) begin errors++; $display("FAIL mid_pre level=%0d ready=%b cpu_in=%h exp 5/0/CAFE", bus.level, bus.host_in_ready, bus.cpu_in); end
        reset = 1'b0;
        bus.cpu_out = 16'h0040;
        tick();
        checks++; if (bus.level !== 4'd0 || bus.host_out_valid !== 1'b0) begin errors++; $display("FAIL mid_fifo level=%0d valid=%b exp 0/0", bus.level, bus.host_out_valid); end
        checks++; if (bus.host_in_ready !== 1'b1 || bus.cpu_in !== 16'h0000 || bus.overflow !== 1'b0) begin errors++; $display("FAIL mid_regs ready=%b cpu_in=%h ovf=%b exp 1/0000/0", bus.host_in_ready, bus.cpu_in, bus.overflow); end
        reset = 1'b1;
        bus.cpu_out = 16'h0041;
        tick();
        tick();
        checks++; if (bus.level !== 4'd0) begin errors++; $display("FAIL mid_first_value level=%0d exp=0", bus.level); end
        bus.cpu_out = 16'h0042;
        tick();
        checks++; if (bus.level !== 4'd1 || bus.host_out_data !== 16'h0042) begin errors++; $display("FAIL mid_rearm level=%0d data=%h exp 1/0042", bus.level, bus.host_out_data); end
    endtask

    initial begin
        bus.cpu_out = 16'h0000;
        bus.host_in_data = 16'h0000;
        bus.host_in_valid = 1'b0;
        bus.host_out_ready = 1'b0;
        bus0.cpu_out = 16'h0000;
        bus0.host_in_data = 16'h0000;
        bus0.host_in_valid = 1'b0;
        bus0.host_out_ready = 1'b0;
        test_reset();
        test_change_detect();
        test_overflow();
        test_full_push_pop();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
